// File: rtl/seg7_pkg.sv
// Shared 7-segment helpers (active-low, bit0=a .. bit6=g) plus the
// conversion FSM state type used by the BCD scan display.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} conv_state_e;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nibble, input logic blank);
    return blank ? SEG_BLANK : digit_to_seg(nibble);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle,
// W iterations per conversion, then a single-cycle done pulse in LATCH.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int W      = 4,
  parameter int DIGITS = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [W-1:0]          i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DIGITS*4-1:0]   o_bcd
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(W + 1);

  conv_state_e        state_q, state_d;
  logic [W-1:0]       shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    adj     = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (i_start) begin
          shift_d = i_bin;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shift_d} = {adj, shift_q} << 1;
        iter_d = iter_q + 1'b1;
        if (iter_q == CNT_W'(W - 1)) state_d = LATCH;
      end
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Busy is registered from the next state so it tracks state_q exactly.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = (state_q == LATCH);
  assign o_bcd  = bcd_q;

endmodule

// File: rtl/bcd_scan_display.sv
// Binary-to-decimal multiplexed 7-segment driver: change detection, display
// register, digit scan, leading-zero blanking and registered outputs.
module bcd_scan_display
  import seg7_pkg::*;
#(
  parameter int W           = 4,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [W-1:0]      i_bin,
  output logic [6:0]        o_HEX,
  output logic [DIGITS-1:0] o_AN,
  output logic              o_busy
);

  localparam int BCD_W = DIGITS * 4;
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (!((10 ** DIGITS) >= (2 ** W))) begin : g_digits_check
    $error("bcd_scan_display: DIGITS too small for W");
  end
  if (REFRESH_DIV < 2) begin : g_refresh_check
    $error("bcd_scan_display: REFRESH_DIV must be at least 2");
  end

  logic               conv_busy;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;
  logic               start;

  logic               pending_q, pending_d;
  logic [W-1:0]       last_bin_q, last_bin_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic [REF_W-1:0]   refresh_q, refresh_d;
  logic [IDX_W-1:0]   digit_idx_q, digit_idx_d;
  logic [6:0]         hex_q, hex_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic [3:0]         sel_nibble;
  logic               blank;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) u_conv (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (start),
    .i_bin   (i_bin),
    .o_busy  (conv_busy),
    .o_done  (conv_done),
    .o_bcd   (conv_bcd)
  );

  // Input changes during a conversion are picked up by the next IDLE compare.
  assign start = !conv_busy && (pending_q || (i_bin != last_bin_q));

  always_comb begin
    pending_d   = pending_q;
    last_bin_d  = last_bin_q;
    disp_d      = conv_done ? conv_bcd : disp_q;
    refresh_d   = refresh_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (start) begin
      pending_d  = 1'b0;
      last_bin_d = i_bin;
    end
    if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
      refresh_d   = '0;
      digit_idx_d = (digit_idx_q == IDX_W'(DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
    end
  end

  // A digit above the LSD is blanked only if it and every higher digit is zero.
  always_comb begin
    sel_nibble = 4'd0;
    blank      = (digit_idx_q != '0);
    an_d       = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (IDX_W'(k) == digit_idx_q) begin
        sel_nibble = disp_q[4*k +: 4];
        an_d[k]    = 1'b0;
      end
      if ((IDX_W'(k) >= digit_idx_q) && (disp_q[4*k +: 4] != 4'd0)) blank = 1'b0;
    end
    hex_d = nibble_to_seg(sel_nibble, blank);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q   <= 1'b1;
      last_bin_q  <= '0;
      disp_q      <= '0;
      refresh_q   <= '0;
      digit_idx_q <= '0;
      hex_q       <= SEG_BLANK;
      an_q        <= '1;
    end else begin
      pending_q   <= pending_d;
      last_bin_q  <= last_bin_d;
      disp_q      <= disp_d;
      refresh_q   <= refresh_d;
      digit_idx_q <= digit_idx_d;
      hex_q       <= hex_d;
      an_q        <= an_d;
    end
  end

  assign o_HEX  = hex_q;
  assign o_AN   = an_q;
  assign o_busy = conv_busy;

endmodule
